wb_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value from memory read data or the ALU result, then commits it to a 32x32 general-purpose register file.
- Serves the decode stage through two asynchronous read ports with same-cycle write bypass, plus a debug read port.
- Keeps a retired-write counter for bring-up and performance checks.

---
 rtl/wb_regfile_if.sv | 36 +++
 rtl/wb_regfile.sv | 70 +++++++
 tb/tb_wb_regfile.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Writeback-side bus for wb_regfile: MEM/WB inputs, decode/debug read ports,
// and the forwarding/status outputs. The master drives the pipeline side.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = 5
);
    // RegWrite qualifies a writeback; with RegWrite low the data, mux select
    // and destination index carry no meaning and may hold any value.
    logic              MemtoReg;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALUResult;
    logic [31:0]       WriteRegister;
    logic [IDX_W-1:0]  rs_addr;
    logic [IDX_W-1:0]  rt_addr;
    logic [IDX_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output MemtoReg, RegWrite, ReadData, ALUResult, WriteRegister,
        output rs_addr, rt_addr, dbg_addr,
        input  rs_data, rt_data, dbg_data, wb_data, wb_valid, retire_cnt
    );

    modport slave (
        input  MemtoReg, RegWrite, ReadData, ALUResult, WriteRegister,
        input  rs_addr, rt_addr, dbg_addr,
        output rs_data, rt_data, dbg_data, wb_data, wb_valid, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the GPR
// file, and serves two bypassed read ports, a raw debug port and a retire counter.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_regfile_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic              unused_widx_hi;

    // Upper destination bits are carried by the pipeline but never decoded.
    assign widx           = bus.WriteRegister[IDX_W-1:0];
    assign unused_widx_hi = ^bus.WriteRegister[31:IDX_W];

    assign wb_data  = bus.MemtoReg ? bus.ReadData : bus.ALUResult;
    assign wb_valid = bus.RegWrite && (widx != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            cnt <= '0;
        end else if (wb_valid) begin
            regs[widx] <= wb_data;
            cnt        <= cnt + CNT_W'(1);
        end
    end

    // Write-first bypass so decode sees the value being committed this cycle.
    always_comb begin
        bus.rs_data = regs[bus.rs_addr];
        if (bus.rs_addr == '0) begin
            bus.rs_data = '0;
        end else if (wb_valid && (bus.rs_addr == widx)) begin
            bus.rs_data = wb_data;
        end
    end

    always_comb begin
        bus.rt_data = regs[bus.rt_addr];
        if (bus.rt_addr == '0) begin
            bus.rt_data = '0;
        end else if (wb_valid && (bus.rt_addr == widx)) begin
            bus.rt_data = wb_data;
        end
    end

    // Debug port shows committed array contents only.
    always_comb begin
        bus.dbg_data = regs[bus.dbg_addr];
        if (bus.dbg_addr == '0) begin
            bus.dbg_data = '0;
        end
    end

    assign bus.wb_data    = wb_data;
    assign bus.wb_valid   = wb_valid;
    assign bus.retire_cnt = cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for mux/commit/bypass plus
// hand sequences for reset, idle hold, mid-stream reset and counter wrap.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_regfile_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(5)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .NUM_REGS(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rw;
    logic        mr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_dbg;
    logic [31:0] e_wb;
    logic        e_valid;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[10];

  // driver tasks
  task automatic drive(input logic rw, input logic mr, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [31:0] wr);
    bus.RegWrite      = rw;
    bus.MemtoReg      = mr;
    bus.ReadData      = rd;
    bus.ALUResult     = alu;
    bus.WriteRegister = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_dbg(input logic [4:0] idx, input logic [31:0] exp);
    bus.dbg_addr = idx;
    #1;
    check($sformatf("dbg[%0d]", idx), bus.dbg_data, exp);
  endtask

  initial begin
    logic [31:0] rnd_rd;
    logic [31:0] rnd_alu;
    logic        rnd_mr;
    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b1, 1'b0, 32'h22222222, 32'h11111111, 32'd8,  5'd8,  5'd0,  5'd8,
                32'h11111111, 32'h0,        32'h0,        32'h11111111, 1'b1, 4'd0};
    vecs[1] = '{1'b1, 1'b1, 32'h22222222, 32'h11111111, 32'd9,  5'd8,  5'd9,  5'd8,
                32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1, 4'd1};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd0,  5'd0,  5'd9,  5'd9,
                32'h0,        32'h22222222, 32'h22222222, 32'hFFFFFFFF, 1'b0, 4'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h33333333, 32'h23, 5'd0,  5'd3,  5'd0,
                32'h0,        32'h33333333, 32'h0,        32'h33333333, 1'b1, 4'd2};
    vecs[4] = '{1'b1, 1'b1, 32'hAAAA0000, 32'h0,        32'd4,  5'd3,  5'd3,  5'd3,
                32'h33333333, 32'h33333333, 32'h33333333, 32'hAAAA0000, 1'b1, 4'd3};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        32'h12345678, 32'd4,  5'd4,  5'd4,  5'd4,
                32'h12345678, 32'h12345678, 32'hAAAA0000, 32'h12345678, 1'b1, 4'd4};
    vecs[6] = '{1'b0, 1'b1, 32'h00005555, 32'h00006666, 32'd4,  5'd4,  5'd9,  5'd4,
                32'h12345678, 32'h22222222, 32'h12345678, 32'h00005555, 1'b0, 4'd5};
    vecs[7] = '{1'b1, 1'b0, 32'h0,        32'h00000001, 32'd10, 5'd10, 5'd10, 5'd10,
                32'h00000001, 32'h00000001, 32'h0,        32'h00000001, 1'b1, 4'd5};
    vecs[8] = '{1'b1, 1'b0, 32'h0,        32'h00000002, 32'd10, 5'd10, 5'd0,  5'd10,
                32'h00000002, 32'h0,        32'h00000001, 32'h00000002, 1'b1, 4'd6};
    vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'd0,  5'd10, 5'd8,  5'd10,
                32'h00000002, 32'h11111111, 32'h00000002, 32'h0,        1'b0, 4'd7};

    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    bus.dbg_addr = '0;

    // reset with a write pending: must be dropped
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'd5);
    step();
    check("wb_data_in_reset", bus.wb_data, 32'hDEADBEEF);
    check("wb_valid_in_reset", {31'b0, bus.wb_valid}, 32'd1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check_dbg(5'(i), 32'h0);
    end
    check("cnt_after_reset", {28'b0, bus.retire_cnt}, 32'd0);

    // vector table
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rw, vecs[v].mr, vecs[v].rd, vecs[v].alu, vecs[v].wr);
      bus.rs_addr  = vecs[v].rs;
      bus.rt_addr  = vecs[v].rt;
      bus.dbg_addr = vecs[v].dbg;
      #1;
      check($sformatf("v%0d_rs", v), bus.rs_data, vecs[v].e_rs);
      check($sformatf("v%0d_rt", v), bus.rt_data, vecs[v].e_rt);
      check($sformatf("v%0d_dbg", v), bus.dbg_data, vecs[v].e_dbg);
      check($sformatf("v%0d_wb", v), bus.wb_data, vecs[v].e_wb);
      check($sformatf("v%0d_valid", v), {31'b0, bus.wb_valid}, {31'b0, vecs[v].e_valid});
      check($sformatf("v%0d_cnt", v), {28'b0, bus.retire_cnt}, {28'b0, vecs[v].e_cnt});
      step();
    end

    // RegWrite low with garbage on the data inputs
    for (int c = 0; c < 10; c++) begin
      rnd_rd  = $urandom;
      rnd_alu = $urandom;
      rnd_mr  = 1'($urandom_range(0, 1));
      drive(1'b0, rnd_mr, rnd_rd, rnd_alu, $urandom);
      #1;
      check("idle_wb_mux", bus.wb_data, rnd_mr ? rnd_rd : rnd_alu);
      check("idle_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      step();
    end
    check_dbg(5'd3, 32'h33333333);
    check_dbg(5'd4, 32'h12345678);
    check_dbg(5'd8, 32'h11111111);
    check_dbg(5'd9, 32'h22222222);
    check_dbg(5'd10, 32'h00000002);
    check("idle_cnt", {28'b0, bus.retire_cnt}, 32'd7);

    // reset mid-stream: write in reset cycle lost, first cycle after release commits
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h00000077, 32'd11);
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'h00000088, 32'h0, 32'd12);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    check_dbg(5'd11, 32'h0);
    check_dbg(5'd12, 32'h00000088);
    check_dbg(5'd8, 32'h0);
    check("rst_mid_cnt", {28'b0, bus.retire_cnt}, 32'd1);

    // counter wrap with a 4-bit counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(k), 32'd1);
      step();
      if (k == 15) check("wrap_cnt_15", {28'b0, bus.retire_cnt}, 32'd15);
      if (k == 16) check("wrap_cnt_16", {28'b0, bus.retire_cnt}, 32'd0);
      if (k == 17) check("wrap_cnt_17", {28'b0, bus.retire_cnt}, 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    check_dbg(5'd1, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
